decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 SHALL have no parameters; all widths are fixed.
REQ-003 SHALL have port: clk  input  1  decode strobe; the CPU phase-2 clock is connected here.
REQ-004 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port: ope  input  32  fetched instruction word; ope[31:24] is the opcode byte and ope[23:16] is the second byte.
REQ-006 SHALL have port: reg_load_1  output  4  destination code for micro-op 1.
REQ-007 SHALL have port: select_1  output  4  source code for micro-op 1.
REQ-008 SHALL have port: reg_load_2  output  4  destination code for micro-op 2.
REQ-009 SHALL have port: select_2  output  4  source code for micro-op 2.
REQ-010 SHALL have port: num_of_ope  output  4  instruction length in bytes.

Function
REQ-011 SHALL use these destination codes: 0 none, 1 stack memory at esp, 2 ebp, 3 eip load, 4 eip relative (eip plus immediate), 5 esp decrement, 6 esp increment.
REQ-012 SHALL use these source codes: 0 none, 1 eip, 2 ebp, 3 esp, 4 stack memory at esp, 5 immediate ope[23:16].
REQ-013 SHALL register all outputs on the rising edge of clk, so every output reflects the ope value sampled at the previous edge (latency 1).
REQ-014 SHALL hold all outputs between edges, whatever ope does in between.
REQ-015 SHALL decode 0x55 (push ebp) as: load_1=1, sel_1=2, load_2=5, sel_2=3, length 1.
REQ-016 SHALL decode 0x5D (pop ebp) as: load_1=2, sel_1=4, load_2=6, sel_2=3, length 1.
REQ-017 SHALL decode 0x89 followed by 0xE5 (mov ebp,esp) as: load_1=2, sel_1=3, load_2=0, sel_2=0, length 2.
REQ-018 SHALL decode 0x89 followed by any second byte other than 0xE5 as undefined.
REQ-019 SHALL decode 0xEB (jmp rel8) as: load_1=4, sel_1=5, micro-op 2 none, length 2.
REQ-020 SHALL decode 0xC3 (ret) as: load_1=3, sel_1=4, load_2=6, sel_2=3, length 1.
REQ-021 SHALL decode 0x90 (nop) as: all load and select codes 0, length 1.
REQ-022 SHALL decode any undefined opcode exactly like nop (length 1), so that the eip always advances.
REQ-023 SHALL ignore ope[15:0] for every opcode.
REQ-024 SHALL never output a nonzero select code whose paired load code is 0, and never a nonzero load code whose paired select code is 0.

Reset
REQ-025 SHALL, when reset is high at a rising edge, set all five outputs to 0 at that edge, with reset taking priority over decoding.
REQ-026 SHALL, when reset is asserted in the middle of a stream, discard the instruction sampled at that edge.
REQ-027 SHALL decode normally at the first edge after reset deasserts.

Structure
REQ-028 SHALL take the destination codes, source codes and opcode constants from a shared package named cpu_pkg, which is also used by the selector, ALU and registers.
REQ-029 SHALL contain a purely combinational sub-module, decode_table (ope to five codes), plus one output register stage; no other sub-modules.

Verification
REQ-030 SHALL be verified by: reset=1 at one edge with ope=0x55000000 -> all outputs 0.
REQ-031 SHALL be verified by: ope=0x55000000 then a clk edge -> outputs 1/2/5/3, num_of_ope=1, with nothing changing before the edge.
REQ-032 SHALL be verified by: ope=0x89E50000 -> outputs 2/3/0/0, length 2; ope=0x89C00000 -> all codes 0, length 1.
REQ-033 SHALL be verified by: ope=0xEB050000 -> load_1=4, sel_1=5, length 2; ope=0xC3000000 -> 3/4/6/3, length 1.
REQ-034 SHALL be verified by: ope=0xFF123456 -> all codes 0, length 1.
REQ-035 SHALL be verified by: stream 0x55, 0x89E5, then reset mid-stream, then 0x5D -> the reset edge gives 0s and the next edge gives 2/4/6/3, length 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: micro-op destination/source codes, opcode constants
// and the decoded-instruction record used by the decoder and datapath blocks.
package cpu_pkg;

    typedef enum logic [3:0] {
        LD_NONE    = 4'd0,
        LD_STACK   = 4'd1,
        LD_EBP     = 4'd2,
        LD_EIP     = 4'd3,
        LD_EIP_REL = 4'd4,
        LD_ESP_DEC = 4'd5,
        LD_ESP_INC = 4'd6
    } dest_t;

    typedef enum logic [3:0] {
        SEL_NONE  = 4'd0,
        SEL_EIP   = 4'd1,
        SEL_EBP   = 4'd2,
        SEL_ESP   = 4'd3,
        SEL_STACK = 4'd4,
        SEL_IMM   = 4'd5
    } src_t;

    localparam logic [7:0] OP_PUSH_EBP = 8'h55;
    localparam logic [7:0] OP_POP_EBP  = 8'h5D;
    localparam logic [7:0] OP_MOV      = 8'h89;
    localparam logic [7:0] OP_JMP_REL8 = 8'hEB;
    localparam logic [7:0] OP_RET      = 8'hC3;
    localparam logic [7:0] OP_NOP      = 8'h90;
    localparam logic [7:0] MODRM_EBP_ESP = 8'hE5;

    typedef struct packed {
        dest_t      load_1;
        src_t       sel_1;
        dest_t      load_2;
        src_t       sel_2;
        logic [3:0] len;
    } decode_t;

    // Undefined opcodes decode as nop so that eip always advances by one byte.
    function automatic decode_t nop_decode();
        decode_t d;
        d.load_1 = LD_NONE;
        d.sel_1  = SEL_NONE;
        d.load_2 = LD_NONE;
        d.sel_2  = SEL_NONE;
        d.len    = 4'd1;
        return d;
    endfunction

endpackage

// File: rtl/decode_table.sv
// Combinational opcode table: instruction word to two micro-ops and length.
// Only the opcode and second byte matter; ope[15:0] never affects the result.
module decode_table
    import cpu_pkg::*;
(
    input  logic [31:0] ope,
    output decode_t     dec
);

    logic [7:0] opcode_s;
    logic [7:0] modrm_s;
    logic       unused_ope_s;

    assign opcode_s     = ope[31:24];
    assign modrm_s      = ope[23:16];
    assign unused_ope_s = ^ope[15:0];

    // Opcode lookup; anything not listed falls back to the nop encoding
    always_comb begin
        dec = nop_decode();
        case (opcode_s)
            OP_PUSH_EBP: begin
                dec.load_1 = LD_STACK;
                dec.sel_1  = SEL_EBP;
                dec.load_2 = LD_ESP_DEC;
                dec.sel_2  = SEL_ESP;
                dec.len    = 4'd1;
            end
            OP_POP_EBP: begin
                dec.load_1 = LD_EBP;
                dec.sel_1  = SEL_STACK;
                dec.load_2 = LD_ESP_INC;
                dec.sel_2  = SEL_ESP;
                dec.len    = 4'd1;
            end
            OP_MOV: begin
                if (modrm_s == MODRM_EBP_ESP) begin
                    dec.load_1 = LD_EBP;
                    dec.sel_1  = SEL_ESP;
                    dec.len    = 4'd2;
                end else begin
                    dec = nop_decode();
                end
            end
            OP_JMP_REL8: begin
                dec.load_1 = LD_EIP_REL;
                dec.sel_1  = SEL_IMM;
                dec.len    = 4'd2;
            end
            OP_RET: begin
                dec.load_1 = LD_EIP;
                dec.sel_1  = SEL_STACK;
                dec.load_2 = LD_ESP_INC;
                dec.sel_2  = SEL_ESP;
                dec.len    = 4'd1;
            end
            OP_NOP: begin
                dec = nop_decode();
            end
            default: begin
                dec = nop_decode();
            end
        endcase
    end

endmodule

// File: rtl/decode.sv
// Instruction decoder: table lookup followed by one output register stage,
// so outputs describe the word sampled at the previous clk edge.
module decode
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ope,
    output logic [3:0]  reg_load_1,
    output logic [3:0]  select_1,
    output logic [3:0]  reg_load_2,
    output logic [3:0]  select_2,
    output logic [3:0]  num_of_ope
);

    decode_t dec_s;

    decode_table u_decode_table (
        .ope (ope),
        .dec (dec_s)
    );

    // Output register; reset discards the word sampled at the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_load_1 <= 4'd0;
            select_1   <= 4'd0;
            reg_load_2 <= 4'd0;
            select_2   <= 4'd0;
            num_of_ope <= 4'd0;
        end else begin
            reg_load_1 <= dec_s.load_1;
            select_1   <= dec_s.sel_1;
            reg_load_2 <= dec_s.load_2;
            select_2   <= dec_s.sel_2;
            num_of_ope <= dec_s.len;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed scenarios plus randomized words
// compared against a table-driven reference model.
module tb_decode;

    logic        clk;
    logic        reset;
    logic [31:0] ope;
    logic [3:0]  reg_load_1;
    logic [3:0]  select_1;
    logic [3:0]  reg_load_2;
    logic [3:0]  select_2;
    logic [3:0]  num_of_ope;

    int total;
    int bad;

    decode dut (
        .clk        (clk),
        .reset      (reset),
        .ope        (ope),
        .reg_load_1 (reg_load_1),
        .select_1   (select_1),
        .reg_load_2 (reg_load_2),
        .select_2   (select_2),
        .num_of_ope (num_of_ope)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {load_1, sel_1, load_2, sel_2, length} straight from the opcode list.
    function automatic logic [19:0] ref_decode(input logic [31:0] w);
        logic [7:0] op;
        logic [7:0] b2;
        op = w[31:24];
        b2 = w[23:16];
        if (op == 8'h55)                   return {4'd1, 4'd2, 4'd5, 4'd3, 4'd1};
        if (op == 8'h5D)                   return {4'd2, 4'd4, 4'd6, 4'd3, 4'd1};
        if (op == 8'h89 && b2 == 8'hE5)    return {4'd2, 4'd3, 4'd0, 4'd0, 4'd2};
        if (op == 8'hEB)                   return {4'd4, 4'd5, 4'd0, 4'd0, 4'd2};
        if (op == 8'hC3)                   return {4'd3, 4'd4, 4'd6, 4'd3, 4'd1};
        return {4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    endfunction

    function automatic logic [19:0] outs();
        return {reg_load_1, select_1, reg_load_2, select_2, num_of_ope};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ope   = 32'h5500_0000;
        step();
        total++;
        if (outs() !== 20'h0) begin
            bad++;
            $display("FAIL reset_state: got %h expected %h", outs(), 20'h0);
        end
        reset = 1'b0;
    endtask

    task automatic test_push_and_hold();
        ope = 32'h5500_0000;
        #2;
        total++;
        if (outs() !== 20'h0) begin
            bad++;
            $display("FAIL push_before_edge: got %h expected %h", outs(), 20'h0);
        end
        step();
        total++;
        if (outs() !== 20'h12531) begin
            bad++;
            $display("FAIL push_ebp: got %h expected %h", outs(), 20'h12531);
        end
        ope = 32'hC300_0000;
        #3;
        ope = 32'h5D00_0000;
        #2;
        total++;
        if (outs() !== 20'h12531) begin
            bad++;
            $display("FAIL hold_between_edges: got %h expected %h", outs(), 20'h12531);
        end
    endtask

    task automatic test_mov();
        ope = 32'h89E5_0000;
        step();
        total++;
        if (outs() !== 20'h23002) begin
            bad++;
            $display("FAIL mov_ebp_esp: got %h expected %h", outs(), 20'h23002);
        end
        ope = 32'h89C0_0000;
        step();
        total++;
        if (outs() !== 20'h00001) begin
            bad++;
            $display("FAIL mov_other_modrm: got %h expected %h", outs(), 20'h00001);
        end
    endtask

    task automatic test_jmp_ret();
        ope = 32'hEB05_0000;
        step();
        total++;
        if (outs() !== 20'h45002) begin
            bad++;
            $display("FAIL jmp_rel8: got %h expected %h", outs(), 20'h45002);
        end
        ope = 32'hC300_0000;
        step();
        total++;
        if (outs() !== 20'h34631) begin
            bad++;
            $display("FAIL ret: got %h expected %h", outs(), 20'h34631);
        end
    endtask

    task automatic test_undefined();
        ope = 32'hFF12_3456;
        step();
        total++;
        if (outs() !== 20'h00001) begin
            bad++;
            $display("FAIL undefined_ff: got %h expected %h", outs(), 20'h00001);
        end
        ope = 32'h9000_0000;
        step();
        total++;
        if (outs() !== 20'h00001) begin
            bad++;
            $display("FAIL nop: got %h expected %h", outs(), 20'h00001);
        end
    endtask

    task automatic test_mid_stream_reset();
        ope = 32'h5500_0000;
        step();
        total++;
        if (outs() !== 20'h12531) begin
            bad++;
            $display("FAIL stream_push: got %h expected %h", outs(), 20'h12531);
        end
        ope = 32'h89E5_0000;
        step();
        total++;
        if (outs() !== 20'h23002) begin
            bad++;
            $display("FAIL stream_mov: got %h expected %h", outs(), 20'h23002);
        end
        reset = 1'b1;
        ope   = 32'hC300_0000;
        step();
        total++;
        if (outs() !== 20'h0) begin
            bad++;
            $display("FAIL stream_reset_edge: got %h expected %h", outs(), 20'h0);
        end
        reset = 1'b0;
        ope   = 32'h5D00_0000;
        step();
        total++;
        if (outs() !== 20'h24631) begin
            bad++;
            $display("FAIL stream_pop_after_reset: got %h expected %h", outs(), 20'h24631);
        end
    endtask

    task automatic test_random();
        logic [7:0]  ops [6];
        logic [19:0] exp;
        logic [7:0]  op;
        logic [7:0]  b2;
        logic        rst;
        ops = '{8'h55, 8'h5D, 8'h89, 8'hEB, 8'hC3, 8'h90};
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3, 0) == 0) op = 8'($urandom);
            else                           op = ops[$urandom_range(5, 0)];
            b2  = ($urandom_range(1, 0) == 0) ? 8'hE5 : 8'($urandom);
            rst = ($urandom_range(15, 0) == 0);
            ope   = {op, b2, 16'($urandom)};
            reset = rst;
            exp   = rst ? 20'h0 : ref_decode(ope);
            step();
            total++;
            if (outs() !== exp) begin
                bad++;
                $display("FAIL random_%0d ope=%h reset=%b: got %h expected %h",
                         i, ope, rst, outs(), exp);
            end
            total++;
            if (((reg_load_1 == 4'd0) != (select_1 == 4'd0)) ||
                ((reg_load_2 == 4'd0) != (select_2 == 4'd0))) begin
                bad++;
                $display("FAIL pairing_%0d: got %h expected matched zero pairs", i, outs());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ope   = 32'h0;
        @(negedge clk);
        test_reset();
        test_push_and_hold();
        test_mov();
        test_jmp_ret();
        test_undefined();
        test_mid_stream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
